tdc_pulse_gen: RTL

- Stimulus transmitter for the TDC measurement core. Drives the TDC's single-pulse-arm input and its measured signal input.
- Emits a programmable number of rising-edge pairs. Within each pair, the two rising edges are exactly a programmed number of clk cycles apart.
- Used for on-board self-test and calibration of the coarse path: each pair must yield a coarse count equal to the effective interval.

---
 rtl/tdc_pulse_gen_if.sv | 35 +++
 rtl/tdc_pulse_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tdc_pulse_gen_if.sv
// Control/status bundle between a sequencer (master) and tdc_pulse_gen (slave).
// sweep_step exists only when TDC_PULSE_GEN_SWEEP_EN is defined.
interface tdc_pulse_gen_if #(
    parameter int CNT_W = 28
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] interval;
    logic [7:0]       num_pairs;
    logic [15:0]      idle_gap;
`ifdef TDC_PULSE_GEN_SWEEP_EN
    logic [7:0]       sweep_step;
`endif
    logic             tdc_arm;
    logic             sig_out;
    logic             busy;
    logic             done;
    logic [7:0]       pairs_sent;

    modport master (
        output start, abort, interval, num_pairs, idle_gap,
`ifdef TDC_PULSE_GEN_SWEEP_EN
        output sweep_step,
`endif
        input  tdc_arm, sig_out, busy, done, pairs_sent
    );

    modport slave (
        input  start, abort, interval, num_pairs, idle_gap,
`ifdef TDC_PULSE_GEN_SWEEP_EN
        input  sweep_step,
`endif
        output tdc_arm, sig_out, busy, done, pairs_sent
    );
endinterface

// File: rtl/tdc_pulse_gen.sv
// TDC self-test stimulus: arms the TDC, then emits rising-edge pairs a programmed interval apart.
// Define TDC_PULSE_GEN_SWEEP_EN to grow the interval by sweep_step after every pair.
module tdc_pulse_gen #(
    parameter int CNT_W    = 28,
    parameter int HIGH_W   = 4,
    parameter int ARM_LEAD = 4
) (
    input logic            clk,
    input logic            rst_n,
    tdc_pulse_gen_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start
    // ARM   | one-cycle tdc_arm pulse
    // LEAD  | sig_out low until ARM_LEAD cycles after arm
    // P1_HI | first pulse high
    // P1_LO | low until int_eff cycles after first rise
    // P2_HI | second pulse high, pair counted
    // GAP   | low for gap_eff cycles before next arm
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LEAD, S_P1_HI, S_P1_LO, S_P2_HI, S_GAP
    } state_t;

    // Counter is at least 16 bits so it can also time idle_gap.
    localparam int CW = (CNT_W > 16) ? CNT_W : 16;
    localparam logic [CNT_W-1:0] MIN_INT = CNT_W'(HIGH_W + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, hi_tc;
    logic [CNT_W-1:0] ival, ival_swept, int_eff;
    logic [7:0]       np_lat, np_eff;
    logic [15:0]      gap_lat, gap_eff;
    logic             launch, finish, sweep_adv;
    logic             arm_nxt, sig_nxt, busy_nxt, done_nxt;
    logic [7:0]       pairs_nxt;

`ifdef TDC_PULSE_GEN_SWEEP_EN
    logic [7:0]       step_lat;
    logic [CNT_W:0]   ival_sum;
    assign ival_sum   = {1'b0, ival} + (CNT_W+1)'(step_lat);
    assign ival_swept = ival_sum[CNT_W] ? '1 : ival_sum[CNT_W-1:0];
`else
    assign ival_swept = ival;
`endif

    assign int_eff   = (ival < MIN_INT) ? MIN_INT : ival;
    assign hi_tc     = CW'(int_eff) - CW'(HIGH_W);
    assign np_eff    = (np_lat == 8'd0) ? 8'd1 : np_lat;
    assign gap_eff   = (gap_lat == 16'd0) ? 16'd1 : gap_lat;
    assign launch    = (state == S_IDLE) && bus.start && !bus.abort;
    assign finish    = (state == S_P2_HI) && (cnt == '0) && (bus.pairs_sent == np_eff) && !bus.abort;
    assign sweep_adv = (state == S_P2_HI) && (cnt == '0) && !finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            ival           <= '0;
            np_lat         <= '0;
            gap_lat        <= '0;
`ifdef TDC_PULSE_GEN_SWEEP_EN
            step_lat       <= '0;
`endif
            bus.tdc_arm    <= 1'b0;
            bus.sig_out    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pairs_sent <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (launch) begin
                ival     <= bus.interval;
                np_lat   <= bus.num_pairs;
                gap_lat  <= bus.idle_gap;
`ifdef TDC_PULSE_GEN_SWEEP_EN
                step_lat <= bus.sweep_step;
`endif
            end else if (sweep_adv) begin
                ival <= ival_swept;
            end
            bus.tdc_arm    <= arm_nxt;
            bus.sig_out    <= sig_nxt;
            bus.busy       <= busy_nxt;
            bus.done       <= done_nxt;
            bus.pairs_sent <= pairs_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '0) ? cnt : cnt - CW'(1);
        case (state)
            S_IDLE:  if (launch) state_nxt = S_ARM;
            S_ARM: begin
                state_nxt = S_LEAD;
                cnt_nxt   = CW'(ARM_LEAD - 2);
            end
            S_LEAD: if (cnt == '0) begin
                state_nxt = S_P1_HI;
                cnt_nxt   = CW'(int_eff) - CW'(1);
            end
            S_P1_HI: if (cnt == hi_tc) state_nxt = S_P1_LO;
            S_P1_LO: if (cnt == '0) begin
                state_nxt = S_P2_HI;
                cnt_nxt   = CW'(HIGH_W - 1);
            end
            S_P2_HI: if (cnt == '0) begin
                if (bus.pairs_sent == np_eff) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_GAP;
                    cnt_nxt   = CW'(gap_eff - 16'd1);
                end
            end
            S_GAP: if (cnt == '0) state_nxt = S_ARM;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_comb begin
        arm_nxt   = (state_nxt == S_ARM);
        sig_nxt   = (state_nxt == S_P1_HI) || (state_nxt == S_P2_HI);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = finish;
        pairs_nxt = bus.pairs_sent;
        if (launch)
            pairs_nxt = '0;
        else if (state == S_P1_LO && state_nxt == S_P2_HI)
            pairs_nxt = bus.pairs_sent + 8'd1;
    end
endmodule
